multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM for a multi-cycle MIPS-style datapath.
// Supported opcodes: R-type, lw, sw, beq, j, addi; bne is added when the
// BNE_SUPPORT_EN macro is defined.
// ILL_HALT selects illegal-opcode handling: 0 returns to IF, 1 parks in HALT.
//
// state  | meaning
// IF     | instruction fetch, waits for mem_ready
// ID     | decode, register read, branch target into ALUOut
// MADDR  | lw/sw effective address
// MRD    | data read, waits for mem_ready
// WBLW   | lw write-back
// MWR    | data write, waits for mem_ready
// EXR    | R-type ALU operation
// WBR    | R-type write-back
// BRANCH | branch compare and conditional PC write
// JUMP   | jump target into PC
// EXI    | addi ALU operation
// WBI    | addi write-back
// HALT   | parked after an illegal opcode; only reset leaves it
module multi_cycle_ctrl #(
  parameter int ILL_HALT = 0
) (
  input  logic       multi_clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] current_state,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       finish,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_WBLW   = 4'd4,
    S_MWR    = 4'd5,
    S_EXR    = 4'd6,
    S_WBR    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_EXI    = 4'd10,
    S_WBI    = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef BNE_SUPPORT_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t r_state;
  logic   r_is_sw;
  logic   r_illegal_op;
  state_t w_id_next;
  logic   w_id_illegal;
  logic   w_branch_qual;

`ifdef BNE_SUPPORT_EN
  logic   r_is_bne;

  // Branch sense comes from the opcode latched in ID: beq takes on zero, bne on !zero.
  assign w_branch_qual = zero ^ r_is_bne;
`else
  // beq-only build: the datapath qualifies the PC write with zero itself.
  assign w_branch_qual = 1'b1 | zero;
`endif

  // Opcode decode used only while in ID.
  always_comb begin
    w_id_next    = S_IF;
    w_id_illegal = 1'b0;
    case (opcode)
      OP_RTYPE:     w_id_next = S_EXR;
      OP_LW, OP_SW: w_id_next = S_MADDR;
      OP_BEQ:       w_id_next = S_BRANCH;
      OP_J:         w_id_next = S_JUMP;
      OP_ADDI:      w_id_next = S_EXI;
`ifdef BNE_SUPPORT_EN
      OP_BNE:       w_id_next = S_BRANCH;
`endif
      default: begin
        w_id_illegal = 1'b1;
        w_id_next    = (ILL_HALT != 0) ? S_HALT : S_IF;
      end
    endcase
  end

  // State register, latched opcode class and registered illegal-opcode pulse.
  always_ff @(posedge multi_clk) begin
    if (!rst_n) begin
      r_state      <= S_IF;
      r_is_sw      <= 1'b0;
      r_illegal_op <= 1'b0;
`ifdef BNE_SUPPORT_EN
      r_is_bne     <= 1'b0;
`endif
    end else begin
      r_illegal_op <= 1'b0;
      case (r_state)
        S_IF:     if (mem_ready) r_state <= S_ID;
        S_ID: begin
          r_state      <= w_id_next;
          r_illegal_op <= w_id_illegal;
          r_is_sw      <= (opcode == OP_SW);
`ifdef BNE_SUPPORT_EN
          r_is_bne     <= (opcode == OP_BNE);
`endif
        end
        S_MADDR:  r_state <= r_is_sw ? S_MWR : S_MRD;
        S_MRD:    if (mem_ready) r_state <= S_WBLW;
        S_MWR:    if (mem_ready) r_state <= S_IF;
        S_EXR:    r_state <= S_WBR;
        S_EXI:    r_state <= S_WBI;
        S_WBLW, S_WBR, S_WBI, S_BRANCH, S_JUMP: r_state <= S_IF;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IF;
      endcase
    end
  end

  // Moore output decode; only the handshake-completion strobes (IR/PC load in IF,
  // finish in MWR) are qualified by mem_ready, since the access ends in that cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    finish        = 1'b0;
    case (r_state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_ID:    alu_src_b = 2'b11;
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WBLW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        finish     = 1'b1;
      end
      S_MWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        finish    = mem_ready;
      end
      S_EXR: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_WBR: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        finish    = 1'b1;
      end
      S_EXI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_WBI: begin
        reg_write = 1'b1;
        finish    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = w_branch_qual;
        finish        = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        finish    = 1'b1;
      end
      default: ;
    endcase
  end

  assign current_state = r_state;
  assign illegal_op    = r_illegal_op;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl. Two instances share stimulus:
// dut with ILL_HALT=1 (fully checked) and dut0 with ILL_HALT=0 (state and
// illegal_op checked). Each cycle's expectation is queued when the inputs are
// driven and popped at the falling edge.
module tb_multi_cycle_ctrl;

  logic       multi_clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic [3:0] current_state, current_state0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, finish, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       pc_write0, pc_write_cond0, i_or_d0, mem_read0, mem_write0, ir_write0;
  logic       mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, finish0, illegal_op0;
  logic [1:0] alu_src_b0, alu_op0, pc_source0;

  int total = 0;
  int bad   = 0;
  logic m_bne = 1'b0;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [3:0] st0;
    logic       ill;
    logic [17:0] outs;
  } exp_t;

  exp_t sb[$];

  always #5 multi_clk = ~multi_clk;

  multi_cycle_ctrl #(.ILL_HALT(1)) dut (
    .multi_clk(multi_clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .current_state(current_state),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .finish(finish), .illegal_op(illegal_op)
  );

  multi_cycle_ctrl #(.ILL_HALT(0)) dut0 (
    .multi_clk(multi_clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .current_state(current_state0),
    .pc_write(pc_write0), .pc_write_cond(pc_write_cond0), .i_or_d(i_or_d0),
    .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0),
    .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0), .reg_write(reg_write0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
    .pc_source(pc_source0), .finish(finish0), .illegal_op(illegal_op0)
  );

  // Expected strobes per state, taken from the state-by-state output list.
  // Packing: pw pwc iod mr mw irw m2r rdst rw asa asb[2] aop[2] psrc[2] fin ill
  function automatic logic [17:0] model(input logic [3:0] st, input logic mr,
                                        input logic z, input logic bne,
                                        input logic ill);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, fin;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, fin} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iod = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; fin = 1'b1; end
      4'd5:  begin mwr = 1'b1; iod = 1'b1; fin = mr; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rdst = 1'b1; fin = 1'b1; end
      4'd8: begin
        asa = 1'b1; aop = 2'b01; psrc = 2'b01; fin = 1'b1;
`ifdef BNE_SUPPORT_EN
        pwc = bne ? ~z : z;
`else
        pwc = 1'b1;
`endif
      end
      4'd9:  begin psrc = 2'b10; pw = 1'b1; fin = 1'b1; end
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: begin rw = 1'b1; fin = 1'b1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, fin, ill};
  endfunction

  task automatic check_one();
    exp_t e;
    logic [17:0] got;
    e = sb.pop_front();
    got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, finish, illegal_op};
    total++;
    assert (current_state === e.st) else begin
      bad++;
      $error("FAIL %s state: got=%0d exp=%0d", e.tag, current_state, e.st);
    end
    total++;
    assert (got === e.outs) else begin
      bad++;
      $error("FAIL %s outputs: got=%b exp=%b", e.tag, got, e.outs);
    end
    total++;
    assert (current_state0 === e.st0) else begin
      bad++;
      $error("FAIL %s state(ILL_HALT=0): got=%0d exp=%0d", e.tag, current_state0, e.st0);
    end
    total++;
    assert (illegal_op0 === e.ill) else begin
      bad++;
      $error("FAIL %s illegal_op(ILL_HALT=0): got=%b exp=%b", e.tag, illegal_op0, e.ill);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare at the falling edge.
  task automatic step(input string tag, input logic rst, input logic [5:0] opc,
                      input logic z, input logic mr, input logic [3:0] est,
                      input logic eill, input logic [3:0] est0);
    exp_t e;
    rst_n = rst; opcode = opc; zero = z; mem_ready = mr;
    e.tag  = tag;
    e.st   = est;
    e.st0  = est0;
    e.ill  = eill;
    e.outs = model(est, mr, z, m_bne, eill);
    sb.push_back(e);
    @(negedge multi_clk);
    check_one();
    @(posedge multi_clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [5:0] opc, input logic z,
                     input logic mr, input logic [3:0] est);
    step(tag, 1'b1, opc, z, mr, est, 1'b0, est);
  endtask

  localparam logic [5:0] XOP = 6'b111111;

  initial begin
    rst_n = 1'b0; opcode = XOP; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge multi_clk);
    #1;
    step("reset", 1'b0, XOP, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);

    // R-type: 0,1,6,7,0
    cyc("rt_if",   XOP,      1'b0, 1'b1, 4'd0);
    cyc("rt_id",   6'b000000, 1'b0, 1'b1, 4'd1);
    cyc("rt_exr",  XOP,      1'b0, 1'b1, 4'd6);
    cyc("rt_wbr",  XOP,      1'b0, 1'b1, 4'd7);

    // lw with three wait cycles in MRD: 8 cycles total
    cyc("lw_if",   XOP,       1'b0, 1'b1, 4'd0);
    cyc("lw_id",   6'b100011, 1'b0, 1'b1, 4'd1);
    cyc("lw_madr", XOP,       1'b0, 1'b1, 4'd2);
    cyc("lw_w1",   XOP,       1'b0, 1'b0, 4'd3);
    cyc("lw_w2",   XOP,       1'b0, 1'b0, 4'd3);
    cyc("lw_w3",   XOP,       1'b0, 1'b0, 4'd3);
    cyc("lw_mrd",  XOP,       1'b0, 1'b1, 4'd3);
    cyc("lw_wb",   XOP,       1'b0, 1'b1, 4'd4);

    // IF holds while mem_ready is low, then sw with one wait
    cyc("if_hold", XOP,       1'b0, 1'b0, 4'd0);
    cyc("sw_if",   XOP,       1'b0, 1'b1, 4'd0);
    cyc("sw_id",   6'b101011, 1'b0, 1'b1, 4'd1);
    cyc("sw_madr", XOP,       1'b0, 1'b1, 4'd2);
    cyc("sw_wait", XOP,       1'b0, 1'b0, 4'd5);
    cyc("sw_done", XOP,       1'b0, 1'b1, 4'd5);

    // addi
    cyc("ai_if",   XOP,       1'b0, 1'b1, 4'd0);
    cyc("ai_id",   6'b001000, 1'b0, 1'b1, 4'd1);
    cyc("ai_exi",  XOP,       1'b0, 1'b1, 4'd10);
    cyc("ai_wbi",  XOP,       1'b0, 1'b1, 4'd11);

    // beq with zero=1 and zero=0
    cyc("beq1_if", XOP,       1'b0, 1'b1, 4'd0);
    cyc("beq1_id", 6'b000100, 1'b0, 1'b1, 4'd1);
    cyc("beq1_br", XOP,       1'b1, 1'b1, 4'd8);
    cyc("beq0_if", XOP,       1'b0, 1'b1, 4'd0);
    cyc("beq0_id", 6'b000100, 1'b0, 1'b1, 4'd1);
    cyc("beq0_br", XOP,       1'b0, 1'b1, 4'd8);

    // j
    cyc("j_if",    XOP,       1'b0, 1'b1, 4'd0);
    cyc("j_id",    6'b000010, 1'b0, 1'b1, 4'd1);
    cyc("j_jump",  XOP,       1'b0, 1'b1, 4'd9);

    // bne
    cyc("bne_if",  XOP,       1'b0, 1'b1, 4'd0);
    cyc("bne_id",  6'b000101, 1'b0, 1'b1, 4'd1);
`ifdef BNE_SUPPORT_EN
    m_bne = 1'b1;
    cyc("bne_br0", XOP,       1'b0, 1'b1, 4'd8);
    cyc("bne_if2", XOP,       1'b0, 1'b1, 4'd0);
    cyc("bne_id2", 6'b000101, 1'b0, 1'b1, 4'd1);
    cyc("bne_br1", XOP,       1'b1, 1'b1, 4'd8);
    m_bne = 1'b0;
`else
    step("bne_ill",  1'b1, XOP, 1'b0, 1'b0, 4'd15, 1'b1, 4'd0);
    step("bne_park", 1'b1, XOP, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0);
    step("bne_rst",  1'b0, XOP, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0);
`endif

    // reset during the MWR wait: back to IF, no write and no finish
    cyc("swr_if",   XOP,       1'b0, 1'b1, 4'd0);
    cyc("swr_id",   6'b101011, 1'b0, 1'b1, 4'd1);
    cyc("swr_madr", XOP,       1'b0, 1'b1, 4'd2);
    cyc("swr_wait", XOP,       1'b0, 1'b0, 4'd5);
    step("swr_rst", 1'b0, XOP, 1'b0, 1'b0, 4'd5, 1'b0, 4'd5);
    cyc("swr_post", XOP,       1'b0, 1'b0, 4'd0);

    // illegal 111111: dut parks in HALT, dut0 returns to IF
    cyc("ill_if",   XOP,       1'b0, 1'b1, 4'd0);
    cyc("ill_id",   XOP,       1'b0, 1'b0, 4'd1);
    step("ill_pulse", 1'b1, XOP, 1'b0, 1'b0, 4'd15, 1'b1, 4'd0);
    step("ill_stay1", 1'b1, XOP, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0);
    step("ill_stay2", 1'b1, 6'b000000, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0);
    step("ill_rst",   1'b0, XOP, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0);
    cyc("ill_after",  XOP,       1'b0, 1'b1, 4'd0);
    cyc("ill_next",   6'b000010, 1'b0, 1'b1, 4'd1);
    cyc("ill_jump",   XOP,       1'b0, 1'b1, 4'd9);
    cyc("end_if",     XOP,       1'b0, 1'b0, 4'd0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: left=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
